// File: rtl/id_ex_hazard_ctrl_if.sv
// Control bus between the ID/EX hazard sequencer and the pipeline registers/PC mux.
// The sequencer takes the slave modport; the pipeline datapath takes master.
interface id_ex_hazard_ctrl_if #(
  parameter int unsigned EXC_CNT_W = 8
);
  logic                 id_valid;
  logic [4:0]           id_rs;
  logic [4:0]           id_rt;
  logic                 ex_mem_read;
  logic [4:0]           ex_rt;
  logic                 ex_md_start;
  logic                 branch_taken;
  logic                 exception;
  logic                 pc_write;
  logic                 if_id_write;
  logic                 if_id_flush;
  logic                 id_ex_write;
  logic                 id_ex_bubble;
  logic                 ex_mem_bubble;
  logic                 epc_load;
  logic [1:0]           pc_sel;
  logic                 md_busy;
  logic [EXC_CNT_W-1:0] exc_cnt;
  logic [1:0]           state_dbg;

  modport master (
    output id_valid, id_rs, id_rt, ex_mem_read, ex_rt, ex_md_start,
           branch_taken, exception,
    input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
           ex_mem_bubble, epc_load, pc_sel, md_busy, exc_cnt, state_dbg
  );

  modport slave (
    input  id_valid, id_rs, id_rt, ex_mem_read, ex_rt, ex_md_start,
           branch_taken, exception,
    output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
           ex_mem_bubble, epc_load, pc_sel, md_busy, exc_cnt, state_dbg
  );
endinterface

// File: rtl/id_ex_hazard_ctrl.sv
// Pipeline sequencer: load-use stall, branch squash, mult/div stall and
// exception flush control for the IF/ID, ID/EX and EX/MEM registers.
module id_ex_hazard_ctrl #(
  parameter int unsigned MD_LAT    = 4,
  parameter int unsigned EXC_CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  id_ex_hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    MD_WAIT   = 2'b01,
    EXC_FLUSH = 2'b10
  } state_t;

  localparam logic [3:0] MD_LOAD = 4'(MD_LAT - 2);

  state_t               state, state_nx;
  logic [3:0]           md_cnt, md_cnt_nx;
  logic                 md_skip, md_skip_nx;
  logic [EXC_CNT_W-1:0] exc_cnt;
  logic                 exc_take;
  logic                 load_use;

  logic       pc_write, if_id_write, if_id_flush, id_ex_write;
  logic       id_ex_bubble, ex_mem_bubble, epc_load, md_busy;
  logic [1:0] pc_sel;

  assign load_use = bus.id_valid && bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
                    ((bus.ex_rt == bus.id_rs) || (bus.ex_rt == bus.id_rt));

  always_comb begin
    state_nx      = state;
    md_cnt_nx     = md_cnt;
    md_skip_nx    = 1'b0;
    exc_take      = 1'b0;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    epc_load      = 1'b0;
    md_busy       = 1'b0;
    pc_sel        = 2'b00;

    unique case (state)
      RUN: begin
        if (bus.exception) begin
          exc_take = 1'b1;
        end else if (bus.branch_taken) begin
          pc_sel       = 2'b01;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (bus.ex_md_start && !md_skip) begin
          md_busy       = 1'b1;
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          ex_mem_bubble = 1'b1;
          md_cnt_nx     = MD_LOAD;
          // MD_LAT=2 needs only this cycle of stall, so MD_WAIT is skipped
          if (MD_LAT > 2) state_nx = MD_WAIT;
          else            md_skip_nx = 1'b1;
        end else if (load_use) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
      end
      MD_WAIT: begin
        if (bus.exception) begin
          exc_take  = 1'b1;
          md_cnt_nx = '0;
        end else begin
          md_busy       = 1'b1;
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          ex_mem_bubble = 1'b1;
          md_cnt_nx     = md_cnt - 4'd1;
          if (md_cnt <= 4'd1) begin
            md_cnt_nx  = '0;
            md_skip_nx = 1'b1;
            state_nx   = RUN;
          end
        end
      end
      EXC_FLUSH: begin
        if_id_flush   = 1'b1;
        id_ex_bubble  = 1'b1;
        ex_mem_bubble = 1'b1;
        state_nx      = RUN;
      end
      default: state_nx = RUN;
    endcase

    if (exc_take) begin
      epc_load      = 1'b1;
      pc_sel        = 2'b10;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
      state_nx      = EXC_FLUSH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      md_cnt  <= '0;
      md_skip <= 1'b0;
      exc_cnt <= '0;
    end else begin
      state   <= state_nx;
      md_cnt  <= md_cnt_nx;
      md_skip <= md_skip_nx;
      if (exc_take && (exc_cnt != '1)) exc_cnt <= exc_cnt + 1'b1;
    end
  end

  // Controls are gated by rst_n so they drop the instant reset asserts.
  assign bus.pc_write      = rst_n & pc_write;
  assign bus.if_id_write   = rst_n & if_id_write;
  assign bus.if_id_flush   = rst_n & if_id_flush;
  assign bus.id_ex_write   = rst_n & id_ex_write;
  assign bus.id_ex_bubble  = rst_n & id_ex_bubble;
  assign bus.ex_mem_bubble = rst_n & ex_mem_bubble;
  assign bus.epc_load      = rst_n & epc_load;
  assign bus.md_busy       = rst_n & md_busy;
  assign bus.pc_sel        = rst_n ? pc_sel : 2'b00;
  assign bus.exc_cnt       = exc_cnt;
  assign bus.state_dbg     = state;

endmodule
